// File: rtl/de_stage.sv
`default_nettype none
// ============================================================================
//  Module      : de_stage
//  Description : Decode stage. Holds the FE/DE pipeline register, decodes
//                instruction fields, reads the external regfile, resolves
//                J / JR / RFE / interrupt redirects, stalls FE on load-use
//                hazards, owns the interrupt-enable state and registers the
//                decoded instruction into the DE/EX register.
//  Revision    : 1.0 - initial release
// ============================================================================
module de_stage #(
    parameter logic [31:0] INT_VEC = 32'h10,
    parameter logic        RST_IEN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] isn,
    input  logic [31:0] pc_cur,
    input  logic [31:0] n_pc,
    input  logic        irq,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    output logic [4:0]  rs_addr,
    output logic [4:0]  rt_addr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [1:0]  ctr,
    output logic [1:0]  jmp_type,
    output logic [31:0] jmp_r,
    output logic [31:0] jmp_i,
    output logic [31:0] epc,
    output logic        dx_valid,
    output logic [31:0] dx_pc,
    output logic [5:0]  dx_op,
    output logic [5:0]  dx_funct,
    output logic [4:0]  dx_rs,
    output logic [4:0]  dx_rt,
    output logic [4:0]  dx_rd,
    output logic [31:0] dx_imm,
    output logic [31:0] dx_a,
    output logic [31:0] dx_b,
    output logic        dx_load,
    output logic        dx_we
);

    localparam logic [5:0] C_OP_RTYPE = 6'h00;
    localparam logic [5:0] C_OP_J     = 6'h02;
    localparam logic [5:0] C_OP_RFE   = 6'h10;
    localparam logic [5:0] C_OP_LW    = 6'h23;
    localparam logic [5:0] C_OP_SW    = 6'h2B;
    localparam logic [5:0] C_FN_JR    = 6'h08;

    localparam logic [1:0] C_JMP_SEQ  = 2'b00;
    localparam logic [1:0] C_JMP_REG  = 2'b01;
    localparam logic [1:0] C_JMP_IMM  = 2'b10;
    localparam logic [1:0] C_JMP_INT  = 2'b11;

    logic        r_valid;
    logic [31:0] r_isn;
    logic [31:0] r_pc;
    logic [31:0] r_npc;
    logic        r_ien;
    logic [31:0] r_epc;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic        w_is_r;
    logic        w_is_jr;
    logic        w_is_j;
    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_is_rfe;
    logic        w_uses_rt;
    logic        w_stall;
    logic        w_active;
    logic        w_irq_take;
    logic        w_rfe_take;
    logic        w_issue;
    logic        w_unused;

    assign w_op    = r_isn[31:26];
    assign w_rs    = r_isn[25:21];
    assign w_rt    = r_isn[20:16];
    assign w_rd    = r_isn[15:11];
    assign w_funct = r_isn[5:0];

    assign w_is_r    = (w_op == C_OP_RTYPE);
    assign w_is_jr   = w_is_r && (w_funct == C_FN_JR);
    assign w_is_j    = (w_op == C_OP_J);
    assign w_is_lw   = (w_op == C_OP_LW);
    assign w_is_sw   = (w_op == C_OP_SW);
    assign w_is_rfe  = (w_op == C_OP_RFE);
    assign w_uses_rt = w_is_r || w_is_sw;

    // Load-use hazard: the EX load result is not yet available for a source we read.
    assign w_stall = r_valid && ex_is_load && (ex_rd != 5'd0) &&
                     ((ex_rd == w_rs) || (w_uses_rt && (ex_rd == w_rt)));

    // A valid, non-stalled instruction is the only one allowed to redirect.
    assign w_active   = r_valid && !w_stall;
    assign w_irq_take = w_active && irq && r_ien;
    assign w_rfe_take = w_active && !w_irq_take && w_is_rfe;
    assign w_issue    = w_active && (jmp_type == C_JMP_SEQ);

    assign rs_addr = w_rs;
    assign rt_addr = w_rt;
    assign ctr     = w_stall ? 2'b10 : 2'b00;
    assign jmp_r   = w_rfe_take ? r_epc : rs_data;
    assign jmp_i   = {r_npc[31:28], r_isn[25:0], 2'b00};
    assign epc     = r_epc;

    // Low NPC bits are carried for completeness; INT_VEC documents the entry PC only.
    assign w_unused = ^{r_npc[27:0], INT_VEC};

    // Redirect selection: interrupt outranks JR/RFE, which outrank J.
    always_comb begin
        jmp_type = C_JMP_SEQ;
        if (w_active) begin
            if (w_irq_take)                jmp_type = C_JMP_INT;
            else if (w_is_jr || w_is_rfe)  jmp_type = C_JMP_REG;
            else if (w_is_j)               jmp_type = C_JMP_IMM;
        end
    end

    // FE/DE register: hold on stall, squash the wrong-path word on redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_isn   <= 32'h0;
            r_pc    <= 32'h0;
            r_npc   <= 32'h0;
        end else if (w_stall) begin
            r_valid <= r_valid;
        end else if (jmp_type != C_JMP_SEQ) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b1;
            r_isn   <= isn;
            r_pc    <= pc_cur;
            r_npc   <= n_pc;
        end
    end

    // Interrupt state: entry saves the interrupted PC and masks, RFE unmasks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ien <= RST_IEN;
            r_epc <= 32'h0;
        end else if (w_irq_take) begin
            r_ien <= 1'b0;
            r_epc <= r_pc;
        end else if (w_rfe_take) begin
            r_ien <= 1'b1;
        end
    end

    // DE/EX register: capture sequential instructions, otherwise insert a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx_valid <= 1'b0;
            dx_pc    <= 32'h0;
            dx_op    <= 6'h0;
            dx_funct <= 6'h0;
            dx_rs    <= 5'h0;
            dx_rt    <= 5'h0;
            dx_rd    <= 5'h0;
            dx_imm   <= 32'h0;
            dx_a     <= 32'h0;
            dx_b     <= 32'h0;
            dx_load  <= 1'b0;
            dx_we    <= 1'b0;
        end else if (!w_issue) begin
            dx_valid <= 1'b0;
        end else begin
            dx_valid <= 1'b1;
            dx_pc    <= r_pc;
            dx_op    <= w_op;
            dx_funct <= w_funct;
            dx_rs    <= w_rs;
            dx_rt    <= w_rt;
            dx_rd    <= w_is_r ? w_rd : w_rt;
            dx_imm   <= {{16{r_isn[15]}}, r_isn[15:0]};
            dx_a     <= rs_data;
            dx_b     <= rt_data;
            dx_load  <= w_is_lw;
            dx_we    <= (w_is_r && !w_is_jr) || w_is_lw;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_de_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_de_stage
//  Description : Directed self-checking bench for de_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_de_stage;

    localparam logic [31:0] C_ADD1 = 32'h00221820; // ADD r3,r1,r2
    localparam logic [31:0] C_ADD2 = 32'h00A03020; // ADD r6,r5,r0
    localparam logic [31:0] C_J40  = 32'h08000010; // J 0x40
    localparam logic [31:0] C_JR7  = 32'h00E00008; // JR r7
    localparam logic [31:0] C_RFE  = 32'h40000000; // RFE
    localparam logic [31:0] C_LW   = 32'h8C24FFFC; // LW r4,-4(r1)
    localparam logic [31:0] C_NOP  = 32'h00000000;

    logic        clk;
    logic        rst;
    logic [31:0] isn;
    logic [31:0] pc_cur;
    logic [31:0] n_pc;
    logic        irq;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [1:0]  ctr;
    logic [1:0]  jmp_type;
    logic [31:0] jmp_r;
    logic [31:0] jmp_i;
    logic [31:0] epc;
    logic        dx_valid;
    logic [31:0] dx_pc;
    logic [5:0]  dx_op;
    logic [5:0]  dx_funct;
    logic [4:0]  dx_rs;
    logic [4:0]  dx_rt;
    logic [4:0]  dx_rd;
    logic [31:0] dx_imm;
    logic [31:0] dx_a;
    logic [31:0] dx_b;
    logic        dx_load;
    logic        dx_we;

    logic [31:0] regs [32];
    int          checks;
    int          errors;

    assign rs_data = regs[rs_addr];
    assign rt_data = regs[rt_addr];

    de_stage #(.INT_VEC(32'h10), .RST_IEN(1'b1)) dut (
        .clk(clk), .rst(rst), .isn(isn), .pc_cur(pc_cur), .n_pc(n_pc),
        .irq(irq), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
        .ctr(ctr), .jmp_type(jmp_type), .jmp_r(jmp_r), .jmp_i(jmp_i), .epc(epc),
        .dx_valid(dx_valid), .dx_pc(dx_pc), .dx_op(dx_op), .dx_funct(dx_funct),
        .dx_rs(dx_rs), .dx_rt(dx_rt), .dx_rd(dx_rd), .dx_imm(dx_imm),
        .dx_a(dx_a), .dx_b(dx_b), .dx_load(dx_load), .dx_we(dx_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] w, input logic [31:0] pc);
        isn    = w;
        pc_cur = pc;
        n_pc   = pc + 32'd4;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h0;
        regs[1] = 32'h11;
        regs[2] = 32'h22;
        regs[5] = 32'h55;
        regs[7] = 32'h100;
        rst = 1'b1; irq = 1'b0; ex_is_load = 1'b0; ex_rd = 5'd0;
        feed(C_NOP, 32'h0);

        // Reset state
        tick(); tick();
        check("rst_dx_valid", {31'h0, dx_valid}, 32'h0);
        check("rst_ctr", {30'h0, ctr}, 32'h0);
        check("rst_jmp_type", {30'h0, jmp_type}, 32'h0);
        check("rst_epc", epc, 32'h0);
        rst = 1'b0;

        // 1: ADD r3,r1,r2 at 0 reaches EX one cycle after entering DE
        feed(C_ADD1, 32'h0);
        tick();
        check("t1_rs_addr", {27'h0, rs_addr}, 32'd1);
        check("t1_rt_addr", {27'h0, rt_addr}, 32'd2);
        check("t1_ctr", {30'h0, ctr}, 32'h0);
        feed(C_ADD2, 32'h4);
        tick();
        check("t1_dx_valid", {31'h0, dx_valid}, 32'h1);
        check("t1_dx_pc", dx_pc, 32'h0);
        check("t1_dx_rd", {27'h0, dx_rd}, 32'd3);
        check("t1_dx_we", {31'h0, dx_we}, 32'h1);
        check("t1_dx_a", dx_a, 32'h11);
        check("t1_dx_b", dx_b, 32'h22);
        check("t1_dx_imm", dx_imm, 32'h1820);
        check("t1_dx_funct", {26'h0, dx_funct}, 32'h20);

        // 2: load-use hazard on r5 stalls ADD r6,r5,r0 for one cycle
        ex_is_load = 1'b1; ex_rd = 5'd5;
        feed(C_J40, 32'h8);
        #1;
        check("t2_ctr_stall", {30'h0, ctr}, 32'h2);
        tick();
        check("t2_dx_bubble", {31'h0, dx_valid}, 32'h0);
        check("t2_hold_rs", {27'h0, rs_addr}, 32'd5);
        check("t2_dx_pc_hold", dx_pc, 32'h0);
        ex_is_load = 1'b0; ex_rd = 5'd0;
        #1;
        check("t2_ctr_clear", {30'h0, ctr}, 32'h0);
        tick();
        check("t2_dx_valid", {31'h0, dx_valid}, 32'h1);
        check("t2_dx_pc", dx_pc, 32'h4);
        check("t2_dx_rd", {27'h0, dx_rd}, 32'd6);
        check("t2_dx_a", dx_a, 32'h55);

        // 3: J 0x40 at pc 0x8, wrong-path word at 0xC squashed
        check("t3_jmp_type", {30'h0, jmp_type}, 32'h2);
        check("t3_jmp_i", jmp_i, 32'h40);
        feed(C_ADD1, 32'hC);
        tick();
        check("t3_squash_jt", {30'h0, jmp_type}, 32'h0);
        check("t3_j_no_issue", {31'h0, dx_valid}, 32'h0);

        // 4: JR r7 with a pending load to r7
        feed(C_JR7, 32'h40);
        tick();
        check("t4_decoded_rs", {27'h0, rs_addr}, 32'd7);
        check("t4_dx_valid", {31'h0, dx_valid}, 32'h0);
        ex_is_load = 1'b1; ex_rd = 5'd7;
        feed(C_NOP, 32'h44);
        #1;
        check("t4_ctr_stall", {30'h0, ctr}, 32'h2);
        check("t4_jt_suppressed", {30'h0, jmp_type}, 32'h0);
        tick();
        ex_is_load = 1'b0; ex_rd = 5'd0;
        #1;
        check("t4_jt_jr", {30'h0, jmp_type}, 32'h1);
        check("t4_jmp_r", jmp_r, 32'h100);
        check("t4_ctr_clear", {30'h0, ctr}, 32'h0);
        tick();
        check("t4_jr_no_issue", {31'h0, dx_valid}, 32'h0);

        // 5: interrupt on ADD at 0x20, then a second irq is masked
        feed(C_ADD1, 32'h20);
        tick();
        irq = 1'b1;
        #1;
        check("t5_jt_int", {30'h0, jmp_type}, 32'h3);
        feed(C_NOP, 32'h24);
        tick();
        check("t5_epc", epc, 32'h20);
        check("t5_dx_bubble", {31'h0, dx_valid}, 32'h0);
        feed(C_ADD1, 32'h10);
        tick();
        check("t5_irq_masked", {30'h0, jmp_type}, 32'h0);

        // 6: RFE returns to epc and re-enables interrupts
        feed(C_RFE, 32'h14);
        irq = 1'b0;
        tick();
        check("t6_dx_valid", {31'h0, dx_valid}, 32'h1);
        check("t6_dx_pc", dx_pc, 32'h10);
        check("t6_jt_rfe", {30'h0, jmp_type}, 32'h1);
        check("t6_jmp_r_epc", jmp_r, 32'h20);
        feed(C_NOP, 32'h18);
        tick();
        check("t6_rfe_no_issue", {31'h0, dx_valid}, 32'h0);
        feed(C_ADD1, 32'h20);
        tick();
        irq = 1'b1;
        #1;
        check("t6_ien_restored", {30'h0, jmp_type}, 32'h3);
        irq = 1'b0;
        feed(C_ADD1, 32'h24);
        tick();
        check("t6_pre_dx_valid", {31'h0, dx_valid}, 32'h1);

        // Async reset during a stall
        ex_is_load = 1'b1; ex_rd = 5'd1;
        #1;
        check("t6_ctr_stall", {30'h0, ctr}, 32'h2);
        rst = 1'b1;
        #1;
        check("t6_rst_dx_valid", {31'h0, dx_valid}, 32'h0);
        check("t6_rst_ctr", {30'h0, ctr}, 32'h0);
        check("t6_rst_epc", epc, 32'h0);
        check("t6_rst_rs", {27'h0, rs_addr}, 32'h0);
        #1;
        rst = 1'b0;
        ex_is_load = 1'b0; ex_rd = 5'd0;
        feed(C_LW, 32'h0);
        tick();
        feed(C_NOP, 32'h4);
        tick();
        check("t6_lw_valid", {31'h0, dx_valid}, 32'h1);
        check("t6_lw_pc", dx_pc, 32'h0);
        check("t6_lw_rd", {27'h0, dx_rd}, 32'd4);
        check("t6_lw_load", {31'h0, dx_load}, 32'h1);
        check("t6_lw_we", {31'h0, dx_we}, 32'h1);
        check("t6_lw_imm", dx_imm, 32'hFFFFFFFC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
